// File: rtl/lsu_mem_ctrl.sv
// ============================================================================
// lsu_mem_ctrl : MEM-stage load/store controller for a word-indexed data RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_mem_ctrl #(
  parameter int MEM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        ram_we,
  output logic [2:0]  ram_func3,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic [29:0] C_DEPTH_W = 30'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WR     = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  func3_q, func3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] merged_q, merged_d;

  logic        w_req_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;
  logic        w_busy_ram;

  // Request legality is judged on the live request bus in the accept cycle.
  always_comb begin
    w_req_err = 1'b0;
    if (req_func3 == 3'b011 || req_func3 == 3'b110 || req_func3 == 3'b111)
      w_req_err = 1'b1;
    if (req_we && (req_func3 == 3'b100 || req_func3 == 3'b101))
      w_req_err = 1'b1;
    if (req_func3[1:0] == 2'b01 && req_addr[0])
      w_req_err = 1'b1;
    if (req_func3 == 3'b010 && req_addr[1:0] != 2'b00)
      w_req_err = 1'b1;
    if (req_addr[31:2] >= C_DEPTH_W)
      w_req_err = 1'b1;
  end

  always_comb begin
    w_byte  = 8'(ram_rdata >> {addr_q[1:0], 3'b000});
    w_half  = 16'(ram_rdata >> {addr_q[1], 4'b0000});
    w_merge = ram_rdata;
    unique case (func3_q)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = ram_rdata;
    endcase
    if (func3_q[1:0] == 2'b00)
      w_merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      w_merge[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    func3_d  = func3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    merged_d = merged_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          func3_d  = req_func3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = w_req_err;
          rdata_d  = 32'd0;
          merged_d = 32'd0;
          if (w_req_err)                state_d = S_RESP;
          else if (!req_we)             state_d = S_RD;
          else if (req_func3 == 3'b010) state_d = S_WR;
          else                          state_d = S_RMW_RD;
        end
      end
      S_RD: begin
        rdata_d = w_load;
        state_d = S_RESP;
      end
      S_WR:     state_d = S_RESP;
      S_RMW_RD: begin
        merged_d = w_merge;
        state_d  = S_RMW_WR;
      end
      S_RMW_WR: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      func3_q  <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
      merged_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      func3_q  <= func3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      merged_q <= merged_d;
    end
  end

  // RAM bus is driven only in states that actually touch memory.
  assign w_busy_ram = (state_q == S_RD) || (state_q == S_WR) ||
                      (state_q == S_RMW_RD) || (state_q == S_RMW_WR);

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = (state_q == S_RESP) && err_q;
  assign resp_rdata = rdata_q;
  assign ram_func3  = 3'b010;
  assign ram_we     = (state_q == S_WR) || (state_q == S_RMW_WR);
  assign ram_addr   = w_busy_ram ? {addr_q[31:2], 2'b00} : 32'd0;
  assign ram_wdata  = (state_q == S_WR)     ? wdata_q  :
                      (state_q == S_RMW_WR) ? merged_q : 32'd0;

  logic w_unused;
  assign w_unused = we_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
// ============================================================================
// tb_lsu_mem_ctrl : randomized self-checking bench against a word-array model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        ram_we;
  logic [2:0]  ram_func3;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] ram   [128];
  logic [31:0] model [128];
  int          n_checks;
  int          n_errors;
  int          n_accepts;
  int          resp_pulses;

  lsu_mem_ctrl #(.MEM_DEPTH(128)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_func3  (req_func3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .ram_we     (ram_we),
    .ram_func3  (ram_func3),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rdata = ram[ram_addr[8:2]];

  always @(posedge clk) if (ram_we) ram[ram_addr[8:2]] <= ram_wdata;
  always @(negedge clk) if (resp_valid) resp_pulses <= resp_pulses + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (we && (f3 == 4 || f3 == 5)) return 1'b1;
    if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) return 1'b1;
    if (f3 == 2 && (a % 4 != 0)) return 1'b1;
    if (a / 4 >= 128) return 1'b1;
    return 1'b0;
  endfunction

  // Issue one request, update the model, and check the response it produces.
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit keep);
    bit          e;
    int          exp_lat;
    int          exp_we;
    int          lat;
    int          wes;
    int          idx;
    int          sh;
    logic [31:0] exp_rd;
    logic [31:0] word;
    logic [31:0] mask;
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_func3 = f3;
    req_addr  = a;
    req_wdata = wd;
    n_accepts++;
    e      = model_err(we, f3, a);
    exp_rd = 32'd0;
    exp_we = 0;
    if (e) begin
      exp_lat = 1;
    end else begin
      idx  = int'(a / 4);
      sh   = int'(a % 4) * 8;
      word = model[idx];
      if (!we) begin
        exp_lat = 2;
        case (f3)
          3'b000: begin exp_rd = (word >> sh) & 32'hFF;   if (exp_rd >= 128)   exp_rd = exp_rd | 32'hFFFF_FF00; end
          3'b001: begin exp_rd = (word >> sh) & 32'hFFFF; if (exp_rd >= 32768) exp_rd = exp_rd | 32'hFFFF_0000; end
          3'b100: exp_rd = (word >> sh) & 32'hFF;
          3'b101: exp_rd = (word >> sh) & 32'hFFFF;
          default: exp_rd = word;
        endcase
      end else if (f3 == 3'b010) begin
        exp_lat    = 2;
        exp_we     = 1;
        model[idx] = wd;
      end else begin
        exp_lat    = 3;
        exp_we     = 1;
        mask       = (f3 == 3'b000) ? 32'hFF : 32'hFFFF;
        model[idx] = (word & ~(mask << sh)) | ((wd & mask) << sh);
      end
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_func3 = 3'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
    end
    lat = 1;
    wes = 0;
    @(negedge clk);
    while (!resp_valid && lat < 10) begin
      chk("ready_busy", {31'd0, req_ready}, 32'd0);
      wes += int'(ram_we);
      @(negedge clk);
      lat++;
    end
    chk("latency",  lat, exp_lat);
    chk("resp_err", {31'd0, resp_err}, {31'd0, e});
    chk("rdata",    resp_rdata, exp_rd);
    chk("ready_resp", {31'd0, req_ready}, 32'd0);
    chk("ram_we_cycles", wes, exp_we);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    n_checks    = 0;
    n_errors    = 0;
    n_accepts   = 0;
    resp_pulses = 0;
    for (int i = 0; i < 128; i++) begin
      ram[i]   = 32'd0;
      model[i] = 32'd0;
    end
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_func3 = 3'd0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("ram_func3", {29'd0, ram_func3}, 32'd2);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    chk("t1_lw", resp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_hold", resp_rdata, 32'hDEADBEEF);

    do_req(1'b1, 3'b000, 32'h11, 32'h000000A5, 1'b0);
    chk("t2_word", ram[4], 32'hDEADA5EF);
    do_req(1'b0, 3'b000, 32'h11, 32'h0, 1'b0);
    chk("t2_lb", resp_rdata, 32'hFFFFFFA5);
    do_req(1'b0, 3'b100, 32'h11, 32'h0, 1'b0);
    chk("t2_lbu", resp_rdata, 32'h000000A5);

    do_req(1'b1, 3'b001, 32'h12, 32'h00001234, 1'b0);
    chk("t3_word", ram[4], 32'h1234A5EF);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, 1'b0);
    chk("t3_lh", resp_rdata, 32'h00001234);
    do_req(1'b0, 3'b101, 32'h10, 32'h0, 1'b0);
    chk("t3_lhu", resp_rdata, 32'h0000A5EF);

    do_req(1'b0, 3'b010, 32'h13,  32'h0, 1'b0);
    do_req(1'b1, 3'b001, 32'h11,  32'hFFFF, 1'b0);
    do_req(1'b0, 3'b011, 32'h10,  32'h0, 1'b0);
    do_req(1'b1, 3'b010, 32'h200, 32'h55, 1'b0);
    chk("t4_word", ram[4], 32'h1234A5EF);

    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    do_req(1'b0, 3'b000, 32'h13, 32'h0, 1'b1);
    do_req(1'b0, 3'b101, 32'h12, 32'h0, 1'b0);

    // Reset during the read half of a byte store must leave RAM untouched.
    do_req(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_func3 = 3'b000;
    req_addr  = 32'h21;
    req_wdata = 32'h5A;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_ready", {31'd0, req_ready}, 32'd1);
    chk("t6_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("t6_resp_err", {31'd0, resp_err}, 32'd0);
    chk("t6_rdata", resp_rdata, 32'd0);
    chk("t6_ram_we", {31'd0, ram_we}, 32'd0);
    chk("t6_ram_addr", ram_addr, 32'd0);
    chk("t6_ram_wdata", ram_wdata, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
    chk("t6_readback", resp_rdata, 32'hCAFEF00D);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      case ($urandom_range(0, 9))
        8:       a = 32'($urandom_range(512, 1023));
        9:       a = $urandom;
        default: a = 32'($urandom_range(0, 511));
      endcase
      if ($urandom_range(0, 3) != 0) begin
        if (f3 == 3'b010) a = a & ~32'd3;
        else if (f3[1:0] == 2'b01) a = a & ~32'd1;
      end
      do_req(1'($urandom), f3, a, $urandom, (n != 299) && ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    chk("resp_pulses", resp_pulses, n_accepts);
    for (int i = 0; i < 128; i++) chk("ram_final", ram[i], model[i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
